ss_scan_ctrl: RTL

- Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
- Drives one shared 0-2 segment decoder: presents each digit's 2-bit code in turn and asserts the matching active-low anode.
- Inserts a blanking gap between digits to suppress ghosting.
- Accepts new display contents over a valid/ready load port and commits them only at frame boundaries, so a frame is never torn.

---
 rtl/ss_pkg.sv | 12 +
 rtl/ss_slot_timer.sv | 58 +++++
 rtl/ss_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared codes and scan state encoding for the seven-segment scan controller
package ss_pkg;

   localparam int SS_CODE_W = 2;
   localparam logic [SS_CODE_W-1:0] SS_CODE_BLANK = 2'd3;

   typedef enum logic {
      SCAN_BLANK = 1'b0,
      SCAN_SHOW  = 1'b1
   } scan_state_e;

endpackage

// File: rtl/ss_slot_timer.sv
// rtl/ss_slot_timer.sv - slot counter and digit index with wrap, en acts as a synchronous clear
module ss_slot_timer
   import ss_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SLOT_CYCLES = 100000,
   parameter int CNT_W       = $clog2(SLOT_CYCLES),
   parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic [IDX_W-1:0] idx_nxt,
   output logic             start,
   output logic             slot_end,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             run;

   // The first enabled edge holds position 0/0 so that slot is shown in full with its frame pulse.
   assign start     = en & ~run;
   assign slot_end  = en & run & (cnt == CNT_LAST);
   assign frame_end = slot_end & (idx == IDX_LAST);

   always_comb begin
      cnt_nxt = '0;
      idx_nxt = '0;
      if (en && run) begin
         if (slot_end) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt_nxt = cnt + 1'b1;
            idx_nxt = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
         run <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         idx <= idx_nxt;
         run <= en;
      end
   end

endmodule

// File: rtl/ss_scan_ctrl.sv
// rtl/ss_scan_ctrl.sv - multiplexed seven-segment scan with blanking gaps and frame-aligned loads
module ss_scan_ctrl
   import ss_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [SS_CODE_W*NUM_DIGITS-1:0] ld_data,
   output logic [SS_CODE_W-1:0]          dig_code,
   output logic [NUM_DIGITS-1:0]         an_n,
   output logic                          frame_start
);

   localparam int CNT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             start;
   logic             slot_end;
   logic             frame_end;

   scan_state_e state;
   scan_state_e state_d;

   logic [SS_CODE_W*NUM_DIGITS-1:0] active;
   logic [SS_CODE_W*NUM_DIGITS-1:0] shadow;
   logic                            pending;
   logic                            commit;

   logic [SS_CODE_W-1:0]  code_sel;
   logic [SS_CODE_W-1:0]  code_d;
   logic [NUM_DIGITS-1:0] an_d;
   logic                  fs_d;

   ss_slot_timer #(
      .NUM_DIGITS  (NUM_DIGITS),
      .SLOT_CYCLES (SLOT_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cnt_nxt   (cnt_nxt),
      .idx_nxt   (idx_nxt),
      .start     (start),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   assign ld_ready = ~pending;
   // Commit looks at the pre-edge pending, so a load landing on a boundary waits a full frame.
   assign commit   = pending & (~en | frame_end);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active  <= {NUM_DIGITS{SS_CODE_BLANK}};
         shadow  <= {NUM_DIGITS{SS_CODE_BLANK}};
         pending <= 1'b0;
      end else if (commit) begin
         active  <= shadow;
         pending <= 1'b0;
      end else if (ld_valid && !pending) begin
         shadow  <= ld_data;
         pending <= 1'b1;
      end
   end

   assign code_sel = active[idx_nxt*SS_CODE_W +: SS_CODE_W];

   // Outputs are computed from the timer's next position so they line up with the slot they describe.
   always_comb begin
      state_d = state;
      an_d    = '1;
      code_d  = SS_CODE_BLANK;
      fs_d    = en & (start | frame_end);
      case (state)
         SCAN_BLANK: if (en && cnt_nxt == CNT_SHOW) state_d = SCAN_SHOW;
         SCAN_SHOW:  if (!en || slot_end)           state_d = SCAN_BLANK;
         default:                                   state_d = SCAN_BLANK;
      endcase
      if (state_d == SCAN_SHOW) begin
         code_d = code_sel;
         if (code_sel != SS_CODE_BLANK) an_d[idx_nxt] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= SCAN_BLANK;
         an_n        <= '1;
         dig_code    <= SS_CODE_BLANK;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         an_n        <= an_d;
         dig_code    <= code_d;
         frame_start <= fs_d;
      end
   end

endmodule
